// File: rtl/ps2_pkg.sv
// Shared types, protocol constants and frame helpers for the PS/2 host side.
package ps2_pkg;

  // Host command sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_TXBIT,
    ST_TXACK,
    ST_WAITRSP
  } ps2_state_e;

  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_SET_LEDS = 8'hED;

  // Odd parity over the data byte: the parity bit makes the total count of ones odd.
  function automatic logic ps2_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Host-to-device frame as shifted out after the start bit: {stop, parity, data}, LSB first.
  function automatic logic [9:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ps2_parity(data), data};
  endfunction

endpackage

// File: rtl/ps2_host_ctrl_if.sv
// Command/response handshake between a client and the PS/2 host sequencer,
// plus the forwarded key-byte stream.
interface ps2_host_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       cmd_has_arg;
  logic [7:0] cmd_arg;
  logic       cmd_ready;
  logic       cmd_done;
  logic       cmd_err;
  logic       key_valid;
  logic [7:0] key_byte;

  // Client side: issues commands, consumes completions and key bytes.
  modport master (
    output cmd_valid, cmd_byte, cmd_has_arg, cmd_arg,
    input  cmd_ready, cmd_done, cmd_err, key_valid, key_byte
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_byte, cmd_has_arg, cmd_arg,
    output cmd_ready, cmd_done, cmd_err, key_valid, key_byte
  );
endinterface

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizer for a raw PS/2 line plus a falling-edge strobe taken
// from the synchronized history. Flops reset to 1 (idle line level) so that
// leaving reset never produces a spurious edge.
module ps2_edge_sync (
  input  logic sysclk,
  input  logic reset,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;

  // Next values of the shift chain.
  always_comb begin
    // NOTE: combinational blocks assign every target on every path, so no latch is inferred.
    meta_d = line_in;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  // Synchronizer and history register.
  always_ff @(posedge sysclk) begin
    // NOTE: clocked state uses non-blocking assignments so all flops sample together.
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign line_sync = sync_q;
  assign fall      = ({hist_q, sync_q} == 2'b10);

endmodule

// File: rtl/ps2_host_ctrl.sv
// Host-side PS/2 command sequencer: inhibits the bus, shifts a command (and an
// optional argument) to the device, checks the line ACK and the device's
// response byte, retries on RESEND/no-ACK/timeout, and forwards unsolicited
// bytes as key data while idle.
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned CLKS_100US  = 5000,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic            sysclk,
  input  logic            reset,
  ps2_host_ctrl_if.slave  cmd_if,
  input  logic            ps2_clk_in,
  input  logic            ps2_dat_in,
  output logic            ps2_clk_oe,
  output logic            ps2_dat_oe,
  input  logic [7:0]      rx_word,
  input  logic            rx_done,
  output logic            rx_hold
);

  localparam int unsigned CNT_MAX = (TIMEOUT > CLKS_100US) ? TIMEOUT : CLKS_100US;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic clk_sync, clk_fall;
  logic dat_sync, dat_fall_unused;

  ps2_edge_sync u_clk_sync (
    .sysclk    (sysclk),
    .reset     (reset),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync),
    .fall      (clk_fall)
  );

  ps2_edge_sync u_dat_sync (
    .sysclk    (sysclk),
    .reset     (reset),
    .line_in   (ps2_dat_in),
    .line_sync (dat_sync),
    .fall      (dat_fall_unused)
  );

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;          // inhibit length, then response timeout
  logic [3:0]       edge_cnt_q, edge_cnt_d; // falling edges seen in this frame
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [7:0]       cmd_byte_q, cmd_byte_d;
  logic [7:0]       cmd_arg_q, cmd_arg_d;
  logic             has_arg_q, has_arg_d;
  logic             sel_arg_q, sel_arg_d;  // 1 while the argument byte is in flight
  logic             ack_seen_q, ack_seen_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             rx_hold_q, rx_hold_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cmd_done_q, cmd_done_d;
  logic             cmd_err_q, cmd_err_d;
  logic             key_valid_q, key_valid_d;
  logic [7:0]       key_byte_q, key_byte_d;

  logic [9:0] frame;
  logic       do_retry;
  logic       timed_out;

  assign frame = ps2_frame(sel_arg_q ? cmd_arg_q : cmd_byte_q);

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_cnt_d  = edge_cnt_q;
    retry_d     = retry_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_arg_d   = cmd_arg_q;
    has_arg_d   = has_arg_q;
    sel_arg_d   = sel_arg_q;
    ack_seen_d  = ack_seen_q;
    dat_oe_d    = dat_oe_q;
    cmd_done_d  = 1'b0;
    cmd_err_d   = 1'b0;
    key_valid_d = 1'b0;
    key_byte_d  = key_byte_q;
    do_retry    = 1'b0;
    timed_out   = (cnt_q == CNT_W'(TIMEOUT - 1));

    unique case (state_q)
      ST_IDLE: begin
        dat_oe_d = 1'b0;
        cnt_d    = '0;
        if (rx_done) begin
          key_valid_d = 1'b1;
          key_byte_d  = rx_word;
        end
        if (cmd_if.cmd_valid && cmd_ready_q) begin
          cmd_byte_d = cmd_if.cmd_byte;
          cmd_arg_d  = cmd_if.cmd_arg;
          has_arg_d  = cmd_if.cmd_has_arg;
          sel_arg_d  = 1'b0;
          retry_d    = '0;
          state_d    = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == CNT_W'(CLKS_100US - 1)) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;               // start bit
          state_d  = ST_RTS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RTS: begin
        cnt_d = cnt_q + 1'b1;
        if (timed_out) begin
          do_retry = 1'b1;
        end else if (clk_fall) begin
          dat_oe_d   = ~frame[0];
          edge_cnt_d = 4'd1;
          state_d    = ST_TXBIT;
        end
      end

      ST_TXBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (timed_out) begin
          do_retry = 1'b1;
        end else if (clk_fall) begin
          if (edge_cnt_q == 4'd9) begin
            dat_oe_d   = 1'b0;           // stop bit: line released for the ACK
            ack_seen_d = 1'b0;
            state_d    = ST_TXACK;
          end else begin
            dat_oe_d   = ~frame[edge_cnt_q];
            edge_cnt_d = edge_cnt_q + 1'b1;
          end
        end
      end

      ST_TXACK: begin
        cnt_d = cnt_q + 1'b1;
        if (timed_out) begin
          do_retry = 1'b1;
        end else if (!ack_seen_q) begin
          if (clk_fall) begin
            if (!dat_sync) ack_seen_d = 1'b1;
            else           do_retry   = 1'b1;
          end
        end else if (clk_sync && dat_sync) begin
          state_d = ST_WAITRSP;
        end
      end

      ST_WAITRSP: begin
        cnt_d = cnt_q + 1'b1;
        if (timed_out) begin
          do_retry = 1'b1;
        end else if (rx_done) begin
          if (rx_word == PS2_ACK) begin
            if (has_arg_q && !sel_arg_q) begin
              sel_arg_d = 1'b1;
              retry_d   = '0;
              cnt_d     = '0;
              state_d   = ST_INHIBIT;
            end else begin
              cmd_done_d = 1'b1;
              state_d    = ST_IDLE;
            end
          end else if (rx_word == PS2_RESEND) begin
            do_retry = 1'b1;
          end else begin
            cmd_done_d = 1'b1;
            cmd_err_d  = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Shared retry path: resend the same byte or give up with an error.
    if (do_retry) begin
      dat_oe_d = 1'b0;
      cnt_d    = '0;
      if (retry_q < RTY_W'(MAX_RETRIES)) begin
        retry_d = retry_q + 1'b1;
        state_d = ST_INHIBIT;
      end else begin
        cmd_done_d = 1'b1;
        cmd_err_d  = 1'b1;
        state_d    = ST_IDLE;
      end
    end

    clk_oe_d    = (state_d == ST_INHIBIT);
    rx_hold_d   = (state_d inside {ST_INHIBIT, ST_RTS, ST_TXBIT, ST_TXACK});
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      edge_cnt_q  <= '0;
      retry_q     <= '0;
      cmd_byte_q  <= '0;
      cmd_arg_q   <= '0;
      has_arg_q   <= 1'b0;
      sel_arg_q   <= 1'b0;
      ack_seen_q  <= 1'b0;
      clk_oe_q    <= 1'b0;
      dat_oe_q    <= 1'b0;
      rx_hold_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      cmd_done_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      key_valid_q <= 1'b0;
      key_byte_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      retry_q     <= retry_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_arg_q   <= cmd_arg_d;
      has_arg_q   <= has_arg_d;
      sel_arg_q   <= sel_arg_d;
      ack_seen_q  <= ack_seen_d;
      clk_oe_q    <= clk_oe_d;
      dat_oe_q    <= dat_oe_d;
      rx_hold_q   <= rx_hold_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_done_q  <= cmd_done_d;
      cmd_err_q   <= cmd_err_d;
      key_valid_q <= key_valid_d;
      key_byte_q  <= key_byte_d;
    end
  end

  assign ps2_clk_oe       = clk_oe_q;
  assign ps2_dat_oe       = dat_oe_q;
  assign rx_hold          = rx_hold_q;
  assign cmd_if.cmd_ready = cmd_ready_q;
  assign cmd_if.cmd_done  = cmd_done_q;
  assign cmd_if.cmd_err   = cmd_err_q;
  assign cmd_if.key_valid = key_valid_q;
  assign cmd_if.key_byte  = key_byte_q;

endmodule
